bullet_pool_ctrl: RTL and testbench
===================================

BULLET_POOL_CTRL -- requirements
Module: bullet_pool_ctrl

Parameters
REQ-001 The block SHALL have parameter STEP, default 5, meaning pixels a bullet rises per accepted frame tick.
REQ-002 The block SHALL have parameter X_OFFSET, default 8, meaning the value added to ship_x for a new bullet's X.
REQ-003 The block SHALL have parameter COOLDOWN, default 12, meaning frame ticks between accepted shots (8-bit).

Interface
REQ-004 iVGA_CLK  in  1  sole clock; all state changes on its rising edge.
REQ-005 iRST_n  in  1  reset, asynchronous, active-low.
REQ-006 frame_tick  in  1  one-cycle pulse once per frame (end of vertical active).
REQ-007 fire  in  1  fire button level, already synchronous to iVGA_CLK.
REQ-008 pause  in  1  level; high freezes the game.
REQ-009 ship_x  in  10  spaceship left X; ship_y  in  9  spaceship top Y.
REQ-010 rd_idx  in  3  renderer slot select.
REQ-011 rd_x  out  10, rd_y  out  9, rd_active  out  1  contents of slot rd_idx, combinational from slot registers.
REQ-012 active_mask  out  8  bit n = slot n active, registered.
REQ-013 fire_ack  out  1  one-cycle pulse, shot allocated; fire_drop  out  1  one-cycle pulse, shot rejected because the pool is full.
REQ-014 busy  out  1  high while the FSM is in SWEEP.

Function
REQ-015 The block SHALL hold 8 slots, each with x[9:0], y[8:0] and active.
REQ-016 The block SHALL register fire into fire_q each cycle; the rising edge (fire & ~fire_q) SHALL set fire_pend, and a held fire SHALL NOT produce further shots.
REQ-017 A frame_tick with pause low SHALL set tick_pend; a frame_tick with pause high SHALL be ignored.
REQ-018 While pause is high, fire_pend SHALL be cleared and no new fire edge SHALL be latched.
REQ-019 The FSM SHALL have states IDLE and SWEEP, plus a 3-bit sweep index.
REQ-020 In IDLE with tick_pend set, the FSM SHALL clear tick_pend, decrement cooldown saturating at 0, set index to 0 and enter SWEEP.
REQ-021 In SWEEP, each cycle the FSM SHALL process slot[index]: if active and y >= STEP, then y <= y - STEP; if active and y < STEP, then active <= 0 with y unchanged, so y never wraps.
REQ-022 After processing index 7, the FSM SHALL return to IDLE; a sweep SHALL therefore last exactly 8 cycles.
REQ-023 A frame_tick arriving during SWEEP SHALL set tick_pend and be serviced on the next IDLE cycle.
REQ-024 In IDLE with tick_pend clear, fire_pend set and cooldown == 0, the block SHALL write the lowest-numbered inactive slot with x = ship_x + X_OFFSET (10-bit, truncated), y = ship_y and active = 1, clear fire_pend, load cooldown with COOLDOWN, and pulse fire_ack in the following cycle.
REQ-025 With fire_pend set, cooldown == 0 and all 8 slots active, the block SHALL clear fire_pend, leave cooldown unchanged and pulse fire_drop.
REQ-026 With fire_pend set and cooldown > 0, fire_pend SHALL remain set until cooldown reaches 0.
REQ-027 When tick_pend and fire_pend are both set in IDLE, the sweep SHALL take priority and the shot SHALL be serviced on the first IDLE cycle after that sweep.
REQ-028 Slots SHALL never be allocated during SWEEP.
REQ-029 fire_ack and fire_drop SHALL never be high in the same cycle.

Reset
REQ-030 On iRST_n low, all slots SHALL clear (x=0, y=0, active=0), and fire_q, fire_pend, tick_pend, cooldown=0, index=0, FSM=IDLE, active_mask=0, fire_ack=0, fire_drop=0 and busy=0, immediately and without waiting for a clock edge.
REQ-031 Reset asserted during SWEEP SHALL abort the sweep; after release, the first frame_tick SHALL start a fresh sweep from slot 0.

Verification
REQ-032 ship_x=320, ship_y=450, fire 0->1 at cycle 10 -> fire_ack at cycle 12; slot0 = (328, 450, 1); active_mask = 8'h01.
REQ-033 One shot, then 3 frame_ticks spaced 20 cycles apart -> slot0.y = 435; busy high for 8 cycles per tick.
REQ-034 Slot at y=3 plus a frame_tick -> slot deactivated, y stays 3, no wrap to 510.
REQ-035 COOLDOWN=0 override, 9 fire edges with no ticks -> 8 fire_ack pulses, the 9th gives fire_drop, active_mask = 8'hFF.
REQ-036 fire edge and frame_tick in the same cycle -> busy for 8 cycles, then fire_ack; a second edge before 12 ticks -> held, acked after the 12th tick.
REQ-037 pause high with frame_ticks and fire edges -> slots unchanged, no ack or drop; iRST_n pulsed mid-sweep -> all outputs 0 at once.

Source files
------------

// File: rtl/bullet_pool_ctrl.sv
// Eight-slot bullet pool: allocates shots on fire edges and moves live bullets
// up by STEP once per accepted frame tick, one slot per cycle.
module bullet_pool_ctrl #(
    parameter int unsigned STEP     = 5,
    parameter int unsigned X_OFFSET = 8,
    parameter int unsigned COOLDOWN = 12
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        frame_tick,
    input  logic        fire,
    input  logic        pause,
    input  logic [9:0]  ship_x,
    input  logic [8:0]  ship_y,
    input  logic [2:0]  rd_idx,
    output logic [9:0]  rd_x,
    output logic [8:0]  rd_y,
    output logic        rd_active,
    output logic [7:0]  active_mask,
    output logic        fire_ack,
    output logic        fire_drop,
    output logic        busy
);

    localparam int unsigned NSLOT = 8;
    localparam int unsigned XW    = 10;
    localparam int unsigned YW    = 9;
    localparam int unsigned IW    = 3;
    localparam int unsigned CW    = 8;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t          state;
    logic [XW-1:0]   slot_x [NSLOT];
    logic [YW-1:0]   slot_y [NSLOT];
    logic [IW-1:0]   idx;
    logic [CW-1:0]   cooldown;
    logic            fire_q;
    logic            fire_pend;
    logic            tick_pend;

    logic            fire_rise_c;
    logic            tick_in_c;
    logic            start_c;
    logic            alloc_c;
    logic            drop_c;
    logic            free_found_c;
    logic [IW-1:0]   free_idx_c;

    assign rd_x      = slot_x[rd_idx];
    assign rd_y      = slot_y[rd_idx];
    assign rd_active = active_mask[rd_idx];

    assign fire_rise_c = fire & ~fire_q & ~pause;
    assign tick_in_c   = frame_tick & ~pause;

    // Lowest-numbered inactive slot wins allocation.
    always_comb begin
        free_found_c = 1'b0;
        free_idx_c   = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!active_mask[i]) begin
                free_found_c = 1'b1;
                free_idx_c   = IW'(i);
            end
        end
    end

    // Sweep always beats a pending shot; shots only resolve in IDLE with cooldown expired.
    assign start_c = (state == IDLE) && tick_pend;
    assign alloc_c = (state == IDLE) && !tick_pend && fire_pend && !pause
                     && (cooldown == '0) && free_found_c;
    assign drop_c  = (state == IDLE) && !tick_pend && fire_pend && !pause
                     && (cooldown == '0) && !free_found_c;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state       <= IDLE;
            idx         <= '0;
            cooldown    <= '0;
            fire_q      <= 1'b0;
            fire_pend   <= 1'b0;
            tick_pend   <= 1'b0;
            active_mask <= '0;
            fire_ack    <= 1'b0;
            fire_drop   <= 1'b0;
            busy        <= 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                slot_x[i] <= '0;
                slot_y[i] <= '0;
            end
        end else begin
            fire_q    <= fire;
            fire_ack  <= alloc_c;
            fire_drop <= drop_c;
            tick_pend <= tick_in_c | (tick_pend & ~start_c);
            if (pause)
                fire_pend <= 1'b0;
            else
                fire_pend <= fire_rise_c | (fire_pend & ~(alloc_c | drop_c));

            case (state)
                IDLE: begin
                    if (start_c) begin
                        if (cooldown != '0)
                            cooldown <= cooldown - CW'(1);
                        idx   <= '0;
                        state <= SWEEP;
                        busy  <= 1'b1;
                    end else if (alloc_c) begin
                        slot_x[free_idx_c]      <= ship_x + XW'(X_OFFSET);
                        slot_y[free_idx_c]      <= ship_y;
                        active_mask[free_idx_c] <= 1'b1;
                        cooldown                <= CW'(COOLDOWN);
                    end
                end
                SWEEP: begin
                    // Bullets reaching the top retire instead of wrapping.
                    if (active_mask[idx]) begin
                        if (slot_y[idx] >= YW'(STEP))
                            slot_y[idx] <= slot_y[idx] - YW'(STEP);
                        else
                            active_mask[idx] <= 1'b0;
                    end
                    idx <= idx + IW'(1);
                    if (idx == IW'(NSLOT - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Directed bench for bullet_pool_ctrl: a default instance plus a COOLDOWN=0 instance.
module tb_bullet_pool_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick, fire, tick0, fire0, pause;
    logic [9:0] ship_x;
    logic [8:0] ship_y;
    logic [2:0] rd_idx;

    logic [9:0] rd_x, rd_x0;
    logic [8:0] rd_y, rd_y0;
    logic       rd_active, rd_active0;
    logic [7:0] mask, mask0;
    logic       ack, drop, busy, ack0, drop0, busy0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bullet_pool_ctrl dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .frame_tick(tick), .fire(fire), .pause(pause),
        .ship_x(ship_x), .ship_y(ship_y), .rd_idx(rd_idx),
        .rd_x(rd_x), .rd_y(rd_y), .rd_active(rd_active), .active_mask(mask),
        .fire_ack(ack), .fire_drop(drop), .busy(busy)
    );

    bullet_pool_ctrl #(.STEP(5), .X_OFFSET(8), .COOLDOWN(0)) dut0 (
        .iVGA_CLK(clk), .iRST_n(rst_n), .frame_tick(tick0), .fire(fire0), .pause(pause),
        .ship_x(ship_x), .ship_y(ship_y), .rd_idx(rd_idx),
        .rd_x(rd_x0), .rd_y(rd_y0), .rd_active(rd_active0), .active_mask(mask0),
        .fire_ack(ack0), .fire_drop(drop0), .busy(busy0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame tick on the default instance; watches busy/ack/drop for 20 cycles.
    task automatic do_tick(input logic with_fire, output int busy_n, output int ack_at,
                           output int drop_n);
        tick = 1'b1;
        if (with_fire) fire = 1'b1;
        step();
        tick   = 1'b0;
        busy_n = 0;
        ack_at = 99;
        drop_n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy) busy_n++;
            if (ack && ack_at == 99) ack_at = i;
            if (drop) drop_n++;
        end
    endtask

    initial begin
        int bn, aa, dn, acks, drops, both, busy_seen;
        logic [8:0] y0_saved, y1_saved;
        rst_n = 1'b1; tick = 0; fire = 0; tick0 = 0; fire0 = 0; pause = 0;
        ship_x = 10'd320; ship_y = 9'd450; rd_idx = 3'd0;

        #2 rst_n = 1'b0;
        #2;
        check("reset_mask", 32'(mask), 32'h00);
        check("reset_ack_drop_busy", {29'd0, ack, drop, busy}, 32'd0);
        check("reset_slot0", {12'd0, rd_x, rd_y, rd_active}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // First shot: edge latched at the next edge, allocated and acked one edge later.
        fire = 1'b1;
        step();
        check("shot_ack_not_early", 32'(ack), 32'd0);
        step();
        check("shot_ack", 32'(ack), 32'd1);
        check("shot_mask", 32'(mask), 32'h01);
        check("shot_x", 32'(rd_x), 32'd328);
        check("shot_y", 32'(rd_y), 32'd450);
        check("shot_active", 32'(rd_active), 32'd1);
        step();
        check("shot_ack_one_cycle", 32'(ack), 32'd0);
        fire = 1'b0;

        for (int t = 1; t <= 3; t++) begin
            do_tick(1'b0, bn, aa, dn);
            check("tick_busy_cycles", 32'(bn), 32'd8);
        end
        check("three_ticks_y", 32'(rd_y), 32'd435);

        // Second shot edge coincides with tick 4; held by cooldown until tick 12.
        ship_x = 10'd100; ship_y = 9'd200;
        acks = 0;
        for (int t = 4; t <= 11; t++) begin
            do_tick(t == 4, bn, aa, dn);
            if (aa != 99) acks++;
            acks += dn;
        end
        check("held_by_cooldown", 32'(acks), 32'd0);
        do_tick(1'b0, bn, aa, dn);
        check("tick12_busy", 32'(bn), 32'd8);
        check("tick12_ack_after_sweep", 32'(aa), 32'd9);
        check("tick12_mask", 32'(mask), 32'h03);
        check("tick12_slot0_y", 32'(rd_y), 32'd390);
        rd_idx = 3'd1;
        #1;
        check("slot1_x", 32'(rd_x), 32'd108);
        check("slot1_y", 32'(rd_y), 32'd200);
        rd_idx = 3'd0;

        // Zero-cooldown instance: retire at top, then fill the pool.
        ship_y = 9'd3;
        fire0 = 1'b1; step(); step();
        check("z_ack", 32'(ack0), 32'd1);
        check("z_y3", 32'(rd_y0), 32'd3);
        fire0 = 1'b0; step();
        tick0 = 1'b1; step(); tick0 = 1'b0;
        for (int i = 0; i < 12; i++) step();
        check("z_retire_mask", 32'(mask0), 32'h00);
        check("z_retire_active", 32'(rd_active0), 32'd0);
        check("z_no_wrap_y", 32'(rd_y0), 32'd3);
        ship_y = 9'd100;
        acks = 0; drops = 0; both = 0;
        for (int k = 0; k < 9; k++) begin
            fire0 = 1'b1;
            for (int j = 0; j < 3; j++) begin
                step();
                if (ack0) acks++;
                if (drop0) drops++;
                if (ack0 && drop0) both++;
            end
            fire0 = 1'b0;
            step();
            if (ack0) acks++;
            if (drop0) drops++;
        end
        check("z_acks", 32'(acks), 32'd8);
        check("z_drops", 32'(drops), 32'd1);
        check("z_ack_drop_exclusive", 32'(both), 32'd0);
        check("z_full_mask", 32'(mask0), 32'hFF);

        // Pause freezes everything.
        fire = 1'b0; step();
        pause = 1'b1; step();
        y0_saved = rd_y;
        rd_idx = 3'd1; #1; y1_saved = rd_y; rd_idx = 3'd0;
        acks = 0; busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick = (i % 10 == 0);
            fire = (i % 10 < 5);
            step();
            if (ack || drop) acks++;
            if (busy) busy_seen++;
        end
        tick = 1'b0; fire = 1'b0; step();
        pause = 1'b0; step(); step();
        check("pause_no_ack_drop", 32'(acks), 32'd0);
        check("pause_no_sweep", 32'(busy_seen), 32'd0);
        check("pause_mask", 32'(mask), 32'h03);
        check("pause_slot0_y", 32'(rd_y), 32'(y0_saved));
        check("pause_slot0_y_const", 32'(rd_y), 32'd390);
        rd_idx = 3'd1; #1;
        check("pause_slot1_y", 32'(rd_y), 32'(y1_saved));
        rd_idx = 3'd0;

        // Reset mid-sweep clears outputs without a clock edge.
        tick = 1'b1; step(); tick = 1'b0; step();
        check("sweep_started", 32'(busy), 32'd1);
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_mask", 32'(mask), 32'h00);
        check("async_mask0", 32'(mask0), 32'h00);
        check("async_slot0", {12'd0, rd_x, rd_y, rd_active}, 32'd0);
        check("async_ack_drop", {30'd0, ack, drop}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        do_tick(1'b0, bn, aa, dn);
        check("post_reset_sweep_busy", 32'(bn), 32'd8);
        check("post_reset_no_ack", 32'(aa), 32'd99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
